// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution controller for the RV32I pipeline.
// Owns a 2-bit bimodal BHT, resolves EX-stage conditional branches against
// the prediction carried with the instruction, issues a registered redirect
// plus a multi-cycle IF/ID flush on a mispredict, stalls on operand hazards
// and counts resolved branches and mispredicts.
module branch_ctrl #(
  parameter int BHT_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_ops_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        br_taken,
  output logic        stall_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_o,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t                state;
  logic [2:0]            fcnt;
  logic [1:0]            bht [BHT_N];
  logic [BHT_IDX_W-1:0]  rd_idx;
  logic [BHT_IDX_W-1:0]  wr_idx;
  logic                  resolve_p0;
  logic                  mispred_p0;
  logic [31:0]           fix_pc_p0;
  logic                  unused_pc_bits;

  // Two-bit saturating counter step: count up on taken, down on not-taken.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    else       return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
  endfunction

  // Corrected fetch PC: the target if the branch was taken, else the
  // fall-through address (wraps naturally at 2**32).
  function automatic logic [31:0] correct_pc(input logic taken, input logic [31:0] pc,
                                             input logic [31:0] tgt);
    return taken ? tgt : pc + 32'd4;
  endfunction

  assign rd_idx = if_pc[BHT_IDX_W+1:2];
  assign wr_idx = ex_pc[BHT_IDX_W+1:2];

  // Only the index bits of the PCs address the BHT.
  assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  // Lookup reads the array before any same-cycle update (no bypass).
  assign pred_taken = bht[rd_idx][1];

  // EX stage: while recovering, the EX contents are wrong-path and ignored.
  assign resolve_p0 = ex_valid & ex_branch & ex_ops_ready & (state == IDLE);
  assign stall_o    = ex_valid & ex_branch & ~ex_ops_ready & (state == IDLE);
  assign mispred_p0 = resolve_p0 & (br_taken != ex_pred_taken);
  assign fix_pc_p0  = correct_pc(br_taken, ex_pc, ex_target);

  // BHT training on every resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (resolve_p0) begin
      bht[wr_idx] <= sat_update(bht[wr_idx], br_taken);
    end
  end

  // Recovery FSM with registered redirect and flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      fcnt           <= 3'd0;
      flush_o        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mispred_p0) begin
            state          <= RECOVER;
            fcnt           <= 3'(FLUSH_CYCLES);
            flush_o        <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= fix_pc_p0;
          end
        end
        RECOVER: begin
          if (fcnt == 3'd1) begin
            state   <= IDLE;
            fcnt    <= 3'd0;
            flush_o <= 1'b0;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        default: begin
          state   <= IDLE;
          fcnt    <= 3'd0;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

  // Statistics counters, wrapping modulo 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (resolve_p0) branch_cnt  <= branch_cnt + 32'd1;
      if (mispred_p0) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the controller.
module tb_branch_ctrl;

  localparam int IDX_W = 4;
  localparam int FC    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid, ex_branch, ex_ops_ready;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken, br_taken;
  logic        stall_o, redirect_valid, flush_o;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_ctrl #(.BHT_IDX_W(IDX_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_ops_ready(ex_ops_ready),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .br_taken(br_taken), .stall_o(stall_o), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_o(flush_o), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: counter values per BHT entry, remaining flush cycles,
  // and the expected registered outputs.
  int          m_bht [1 << IDX_W];
  int          m_flush_left = 0;
  bit          m_rv = 0;
  bit [31:0]   m_rpc = 0;
  bit [31:0]   m_bcnt = 0;
  bit [31:0]   m_mcnt = 0;

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[pc[IDX_W+1:2]] >= 2;
  endfunction

  function automatic bit m_stall();
    return ex_valid && ex_branch && !ex_ops_ready && (m_flush_left == 0);
  endfunction

  task automatic m_update();
    int idx;
    if (rst) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_flush_left = 0; m_rv = 0; m_rpc = 0; m_bcnt = 0; m_mcnt = 0;
    end else begin
      m_rv = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (ex_valid && ex_branch && ex_ops_ready) begin
        idx = int'(ex_pc[IDX_W+1:2]);
        m_bcnt++;
        if (br_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else          m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        if (br_taken != ex_pred_taken) begin
          m_mcnt++;
          m_rv  = 1;
          m_rpc = br_taken ? ex_target : ex_pc + 32'd4;
          m_flush_left = FC;
        end
      end
    end
  endtask

  // Advance one clock: update the model at the edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  // Drive EX/IF inputs (called at the falling edge) and let them settle.
  task automatic drive(input bit v, input bit b, input bit rdy, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit pt, input bit tk,
                       input logic [31:0] ipc);
    ex_valid = v; ex_branch = b; ex_ops_ready = rdy; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pt; br_taken = tk; if_pc = ipc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h100);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h100);
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b want 0", pred_taken); end
    vectors++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
    vectors++;
    if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %0b want 0", redirect_valid); end
    vectors++;
    if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
    vectors++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", flush_o); end
    vectors++;
    if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
    end
    vectors++;
  endtask

  task automatic test_mispredict_taken();
    drive(1, 1, 1, 32'h100, 32'h80, 0, 1, 32'h100);
    if (stall_o !== 1'b0) begin errors++; $display("FAIL mt_stall: got %0b want 0", stall_o); end
    vectors++;
    tick();
    // Cycle N+1: redirect pulse and first flush cycle; wrong-path branch offered.
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin
      errors++; $display("FAIL mt_redirect: got %0b/%h want 1/00000080", redirect_valid, redirect_pc);
    end
    vectors++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL mt_flush1: got %0b want 1", flush_o); end
    vectors++;
    if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin
      errors++; $display("FAIL mt_cnt: got %0d/%0d want 1/1", branch_cnt, mispred_cnt);
    end
    vectors++;
    drive(1, 1, 1, 32'h200, 32'h300, 1, 0, 32'h100);
    tick();
    // Cycle N+2: still flushing; stalled-looking branch must not stall.
    if (redirect_valid !== 1'b0 || flush_o !== 1'b1) begin
      errors++; $display("FAIL mt_flush2: got rv=%0b fl=%0b want rv=0 fl=1", redirect_valid, flush_o);
    end
    vectors++;
    drive(1, 1, 0, 32'h200, 32'h300, 1, 0, 32'h100);
    if (stall_o !== 1'b0) begin errors++; $display("FAIL mt_stall_recover: got %0b want 0", stall_o); end
    vectors++;
    tick();
    // Cycle N+3: back in IDLE, wrong-path branches left no trace.
    if (flush_o !== 1'b0) begin errors++; $display("FAIL mt_flush3: got %0b want 0", flush_o); end
    vectors++;
    if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin
      errors++; $display("FAIL mt_ignored: got %0d/%0d want 1/1", branch_cnt, mispred_cnt);
    end
    vectors++;
    drive(0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h100);
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL mt_bht: got %0b want 1", pred_taken); end
    vectors++;
  endtask

  task automatic test_training();
    do_reset();
    // First correct taken resolve: same-cycle lookup still sees the old counter.
    drive(1, 1, 1, 32'h100, 32'h40, 1, 1, 32'h100);
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL tr_collision: got %0b want 0", pred_taken); end
    vectors++;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1, 1, 1, 32'h100, 32'h40, 1, 1, 32'h100);
      if (pred_taken !== 1'b1) begin errors++; $display("FAIL tr_pred%0d: got %0b want 1", i, pred_taken); end
      vectors++;
      if (redirect_valid !== 1'b0 || flush_o !== 1'b0) begin
        errors++; $display("FAIL tr_noredir%0d: got rv=%0b fl=%0b want 0/0", i, redirect_valid, flush_o);
      end
      vectors++;
      if (branch_cnt !== 32'(i + 1)) begin
        errors++; $display("FAIL tr_bcnt%0d: got %0d want %0d", i, branch_cnt, i + 1);
      end
      vectors++;
    end
    // Third taken resolve happened in the loop's last cycle; now two not-taken
    // (correctly predicted) resolves: 11 -> 10 -> 01.
    drive(1, 1, 1, 32'h100, 32'h40, 0, 0, 32'h100);
    tick();
    drive(1, 1, 1, 32'h100, 32'h40, 0, 0, 32'h100);
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL tr_sat_hi: got %0b want 1", pred_taken); end
    vectors++;
    tick();
    drive(0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h100);
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL tr_down: got %0b want 0", pred_taken); end
    vectors++;
    if (branch_cnt !== 32'd5 || mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL tr_cnt: got %0d/%0d want 5/0", branch_cnt, mispred_cnt);
    end
    vectors++;
  endtask

  task automatic test_wrap();
    drive(1, 1, 1, 32'hFFFF_FFFC, 32'h1234_5678, 1, 0, 32'h100);
    tick();
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_rpc: got %0b/%h want 1/00000000", redirect_valid, redirect_pc);
    end
    vectors++;
    drive(0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h100);
    tick(); tick();
    if (flush_o !== 1'b0) begin errors++; $display("FAIL wrap_flush_end: got %0b want 0", flush_o); end
    vectors++;
  endtask

  task automatic test_stall();
    logic [31:0] base;
    base = branch_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'h108, 32'h500, 0, 0, 32'h108);
      if (stall_o !== 1'b1) begin errors++; $display("FAIL st_high%0d: got %0b want 1", i, stall_o); end
      vectors++;
      tick();
      if (branch_cnt !== base) begin errors++; $display("FAIL st_hold%0d: got %0d want %0d", i, branch_cnt, base); end
      vectors++;
    end
    drive(1, 1, 1, 32'h108, 32'h500, 0, 0, 32'h108);
    if (stall_o !== 1'b0) begin errors++; $display("FAIL st_release: got %0b want 0", stall_o); end
    vectors++;
    tick();
    drive(0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h108);
    if (branch_cnt !== base + 32'd1) begin
      errors++; $display("FAIL st_once: got %0d want %0d", branch_cnt, base + 32'd1);
    end
    vectors++;
  endtask

  task automatic test_reset_mid_recover();
    drive(1, 1, 1, 32'h10C, 32'h900, 0, 1, 32'h100);
    tick();
    if (flush_o !== 1'b1) begin errors++; $display("FAIL rr_flush: got %0b want 1", flush_o); end
    vectors++;
    rst = 1'b1;
    drive(1, 1, 1, 32'h110, 32'h900, 0, 1, 32'h100);
    tick();
    rst = 1'b0;
    if (flush_o !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL rr_cleared: got fl=%0b rv=%0b want 0/0", flush_o, redirect_valid);
    end
    vectors++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL rr_cnt: got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
    end
    vectors++;
    drive(1, 1, 0, 32'h110, 32'h900, 0, 1, 32'h10C);
    if (stall_o !== 1'b1 || pred_taken !== 1'b0) begin
      errors++; $display("FAIL rr_idle: got stall=%0b pred=%0b want 1/0", stall_o, pred_taken);
    end
    vectors++;
    // Reset in IDLE beats a simultaneous mispredicting resolve.
    rst = 1'b1;
    drive(1, 1, 1, 32'h110, 32'h900, 0, 1, 32'h110);
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h110);
    if (branch_cnt !== 32'd0 || redirect_valid !== 1'b0 || flush_o !== 1'b0 || pred_taken !== 1'b0) begin
      errors++; $display("FAIL rr_priority: got cnt=%0d rv=%0b fl=%0b pred=%0b want 0/0/0/0",
                         branch_cnt, redirect_valid, flush_o, pred_taken);
    end
    vectors++;
  endtask

  task automatic test_random();
    logic [31:0] pcs [5];
    logic [31:0] pc, ipc;
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h140; pcs[3] = 32'hFFFF_FFFC; pcs[4] = 32'h13C;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      pc  = ($urandom_range(0, 5) == 5) ? ($urandom & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 4)];
      ipc = pcs[$urandom_range(0, 4)];
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
            pc, $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom), ipc);
      if (pred_taken !== m_pred(if_pc)) begin
        errors++; $display("FAIL rnd_pred@%0d: got %0b want %0b", n, pred_taken, m_pred(if_pc));
      end
      vectors++;
      if (stall_o !== m_stall()) begin
        errors++; $display("FAIL rnd_stall@%0d: got %0b want %0b", n, stall_o, m_stall());
      end
      vectors++;
      tick();
      if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc)) begin
        errors++; $display("FAIL rnd_redirect@%0d: got %0b/%h want %0b/%h", n, redirect_valid, redirect_pc, m_rv, m_rpc);
      end
      vectors++;
      if (flush_o !== (m_flush_left > 0)) begin
        errors++; $display("FAIL rnd_flush@%0d: got %0b want %0b", n, flush_o, m_flush_left > 0);
      end
      vectors++;
      if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
        errors++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
      end
      vectors++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_branch = 0; ex_ops_ready = 1; ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; br_taken = 0; if_pc = 0;
    @(negedge clk);
    test_reset();
    test_mispredict_taken();
    test_training();
    test_wrap();
    test_stall();
    test_reset_mid_recover();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard upper bound on simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution controller for the pipelined RV32I core. It sits beside the EX-stage branch comparator and owns a small 2-bit bimodal branch history table (BHT). It supplies a taken prediction to fetch, checks each resolved conditional branch against its prediction, and on a mispredict issues a registered PC redirect plus a multi-cycle IF/ID flush. It also stalls the pipeline while branch operands are not ready and keeps branch and mispredict statistics.

## Interface
Parameters:
- BHT_IDX_W, 4, BHT index width; the BHT has 2**BHT_IDX_W entries indexed by pc[BHT_IDX_W+1:2]
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after a mispredict (legal range 1..7)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  32  fetch-stage PC used for the BHT lookup
- pred_taken  out  1  prediction for if_pc (MSB of the BHT counter), combinational
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  EX instruction is a conditional branch; the same signal drives the comparator's branch input
- ex_ops_ready  in  1  both comparator operands are final (no pending load-use)
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  branch target computed by the ALU
- ex_pred_taken  in  1  prediction carried down the pipeline with the instruction
- br_taken  in  1  comparator result
- stall_o  out  1  hold EX and all upstream stages, combinational
- redirect_valid  out  1  single-cycle pulse, registered
- redirect_pc  out  32  corrected fetch PC, valid while redirect_valid is high
- flush_o  out  1  kill IF/ID contents, registered
- branch_cnt  out  32  resolved branch count
- mispred_cnt  out  32  mispredict count

## Operation
- FSM has two states: IDLE and RECOVER, plus a flush counter fcnt of 3 bits.
- Resolve event: ex_valid & ex_branch & ex_ops_ready & state==IDLE.
- stall_o = ex_valid & ex_branch & !ex_ops_ready & state==IDLE.
- Mispredict condition: resolve & (br_taken != ex_pred_taken).
- Redirect PC on mispredict:
  - br_taken=1: redirect_pc = ex_target.
  - br_taken=0: redirect_pc = ex_pc + 4, modulo 2**32 (0xFFFFFFFC wraps to 0).
- Behaviour on a resolve:
  - branch_cnt increments.
  - The BHT entry at ex_pc[BHT_IDX_W+1:2] updates with a saturating counter: +1 if taken, -1 if not taken, held at 3 and at 0.
- Behaviour on a mispredict:
  - mispred_cnt increments.
  - redirect_valid and redirect_pc are registered.
  - The FSM enters RECOVER with fcnt=FLUSH_CYCLES.
- RECOVER state:
  - flush_o is high.
  - fcnt decrements each cycle; the FSM returns to IDLE after the cycle in which fcnt reaches 1.
  - EX inputs are ignored (wrong path): no resolve, no stall, no BHT or counter update.
- Statistics counters wrap modulo 2**32.
- BHT read/write collision (if_pc index equals the update index in the same cycle): the read returns the pre-update value; there is no bypass.
- Non-branch or invalid EX instructions have no effect.
- Reset values:
  - All BHT entries = 2'b01 (weakly not-taken), so pred_taken=0 after reset.
  - state=IDLE, fcnt=0.
  - redirect_valid=0, redirect_pc=0, flush_o=0.
  - branch_cnt=0, mispred_cnt=0.
- Reset asserted during RECOVER: the next edge forces IDLE, flush_o drops, and counters and BHT reinitialise. Reset has priority over a simultaneous resolve.

## Timing
- pred_taken and stall_o are combinational from the current inputs and state; no added latency.
- A mispredict resolved in cycle N gives:
  - redirect_valid=1 in cycle N+1 only;
  - flush_o=1 in cycles N+1 through N+FLUSH_CYCLES;
  - a first resolve again possible in cycle N+FLUSH_CYCLES+1.
- The BHT update from a resolve in cycle N is visible to pred_taken in cycle N+1.
- A correctly predicted branch produces no redirect and no flush. A back-to-back correct branch can resolve in cycle N+1.
- A stalled branch resolves in the first cycle in which ex_ops_ready=1. It is counted exactly once.

## Test plan
- Reset, then if_pc=0x100: pred_taken=0; all counters read 0.
- Mispredict, taken: ex_pc=0x100, ex_pred_taken=0, br_taken=1, ex_target=0x80.
  - Next cycle: redirect_valid=1, redirect_pc=0x80.
  - flush_o high for 2 cycles.
  - mispred_cnt=1, branch_cnt=1.
  - A branch presented in EX during the flush is ignored.
- Training: repeat the taken resolve at ex_pc=0x100 three times with correct predictions. The counter goes 01→10→11→11 (saturates), and pred_taken for if_pc=0x100 becomes 1 after the first update.
- Mispredict, not-taken wrap: ex_pred_taken=1, br_taken=0, ex_pc=0xFFFFFFFC gives redirect_pc=0x00000000.
- Stall: ex_ops_ready=0 for 3 cycles, then 1. stall_o is high for exactly those 3 cycles, and branch_cnt increments by exactly 1.
- Reset mid-RECOVER: rst asserted in cycle N+1 of a flush. flush_o=0 and state=IDLE from cycle N+2, and a resolve in that same reset cycle is not counted.
